// File: rtl/hazard_fwd_unit.sv
// Hazard detection and EX operand-forwarding control for a 5-stage MIPS pipeline.
// A private scoreboard tracks EX/MEM/WB destinations; stall/bubble/flush are combinational.
module hazard_fwd_unit #(
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             redirect,
    output logic             stall_if,
    output logic             bubble_ex,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] dst;
        logic            reg_write;
        logic            mem_read;
    } sb_entry_t;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    sb_entry_t        r_ex;
    sb_entry_t        r_mem;
    sb_entry_t        r_wb;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Register 0 is hard-wired, so a write to it never creates a dependence.
    function automatic logic entry_match(input sb_entry_t e, input logic [RA_W-1:0] src);
        return e.valid && e.reg_write && (e.dst == src) && (src != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
        if (ex_hit)
            return FWD_EXMEM;
        else if (mem_hit)
            return FWD_MEMWB;
        return FWD_NONE;
    endfunction

    logic      w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
    logic      w_needs_b;
    logic      w_hz_load_use;
    logic      w_hz_raw;
    logic      w_hz;
    logic      w_flush;
    logic      w_stall;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;
    sb_entry_t w_ex_nxt;
    logic      w_unused_mem_read;

    assign w_needs_b = id_uses_rt;

    assign w_ex_rs  = entry_match(r_ex,  id_rs);
    assign w_ex_rt  = entry_match(r_ex,  id_rt);
    assign w_mem_rs = entry_match(r_mem, id_rs);
    assign w_mem_rt = entry_match(r_mem, id_rt);
    assign w_wb_rs  = entry_match(r_wb,  id_rs);
    assign w_wb_rt  = entry_match(r_wb,  id_rt);

    // With forwarding only a load in EX cannot supply its result in time.
    assign w_hz_load_use = id_valid && r_ex.mem_read && (w_ex_rs || (w_needs_b && w_ex_rt));
    assign w_hz_raw      = id_valid && ((w_ex_rs || w_mem_rs || w_wb_rs) ||
                           (w_needs_b && (w_ex_rt || w_mem_rt || w_wb_rt)));
    assign w_hz          = (FWD_EN != 0) ? w_hz_load_use : w_hz_raw;

    assign w_flush   = !rst && redirect;
    assign w_stall   = !rst && w_hz && !w_flush;

    assign flush     = w_flush;
    assign stall_if  = w_stall;
    assign bubble_ex = w_stall || w_flush;

    // Only the EX entry's mem_read is ever consulted; older copies just ride along.
    assign w_unused_mem_read = r_mem.mem_read ^ r_wb.mem_read;

    always_comb begin
        w_ex_nxt.valid     = id_valid && !w_stall && !w_flush;
        w_ex_nxt.dst       = id_dst;
        w_ex_nxt.reg_write = id_reg_write;
        w_ex_nxt.mem_read  = id_mem_read;
    end

    // The select is computed against the current EX/MEM entries, which become
    // EX/MEM and MEM/WB respectively when this ID instruction enters EX.
    always_comb begin
        w_fwd_a_nxt = FWD_NONE;
        w_fwd_b_nxt = FWD_NONE;
        if ((FWD_EN != 0) && !w_stall && !w_flush) begin
            w_fwd_a_nxt = fwd_sel(w_ex_rs, w_mem_rs);
            if (w_needs_b)
                w_fwd_b_nxt = fwd_sel(w_ex_rt, w_mem_rt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_fwd_a <= FWD_NONE;
            r_fwd_b <= FWD_NONE;
        end else begin
            r_wb    <= r_mem;
            r_mem   <= w_flush ? '0 : r_ex;
            r_ex    <= w_ex_nxt;
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
